// File: rtl/uart_rx_word.sv
// uart_rx_word: oversampling UART receiver that deframes start/data/optional
// parity/stop bits and packs four consecutive bytes (first byte in [7:0])
// into a 32-bit word offered downstream on a valid/ready handshake.
// Framing, parity and overrun errors are reported as one-cycle pulses.
// dbg_state mirrors the receiver FSM state for observation.
module uart_rx_word #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SAMPLE_PT    = (CLKS_PER_BIT - 1) / 2
) (
   input  logic        clk,
   input  logic        ap_rst,
   input  logic        rx,
   input  logic        parity_en,
   input  logic        ap_ready,
   output logic        ap_vaild,
   output logic [31:0] data,
   output logic        frame_err,
   output logic        parity_err,
   output logic        overrun,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   localparam logic [9:0] BIT_LAST = 10'(CLKS_PER_BIT - 1);
   localparam logic [9:0] SAMPLE   = 10'(SAMPLE_PT);

   state_t      state, state_n;
   logic        rx_meta, rxs;
   logic [9:0]  bcnt;
   logic [2:0]  idx;
   logic [1:0]  byte_idx;
   logic [7:0]  shift;
   logic [23:0] asm_lo;
   logic        par_lat, par_bad;

   logic at_sample, bit_end, word_done;
   logic shift_en, par_latch, par_check, idx_clr, idx_inc;
   logic byte_ok, frame_hit, parity_hit;

   assign at_sample = (bcnt == SAMPLE);
   assign bit_end   = (bcnt == BIT_LAST);
   assign word_done = byte_ok && (byte_idx == 2'd3);
   assign dbg_state = state;

   // Two-flop synchronizer for the asynchronous serial line, idling high.
   always_ff @(posedge clk or posedge ap_rst) begin
      if (ap_rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge ap_rst) begin
      if (ap_rst) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state decode and per-cycle datapath strobes.
   always_comb begin
      state_n    = state;
      shift_en   = 1'b0;
      par_latch  = 1'b0;
      par_check  = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      byte_ok    = 1'b0;
      frame_hit  = 1'b0;
      parity_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rxs) state_n = S_START;
         end
         S_START: begin
            if (at_sample && rxs) begin
               state_n = S_IDLE;              // glitch, not a real start bit
            end else begin
               if (at_sample) par_latch = 1'b1;
               if (bit_end) begin
                  state_n = S_DATA;
                  idx_clr = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (at_sample) shift_en = 1'b1;
            if (bit_end) begin
               if (idx == 3'd7) state_n = par_lat ? S_PARITY : S_STOP;
               else             idx_inc = 1'b1;
            end
         end
         S_PARITY: begin
            if (at_sample) par_check = 1'b1;
            if (bit_end)   state_n   = S_STOP;
         end
         S_STOP: begin
            // Decide at the stop sample; no need to wait out the stop bit.
            if (at_sample) begin
               if (!rxs) begin
                  frame_hit = 1'b1;
                  state_n   = S_BREAK;
               end else if (par_bad) begin
                  parity_hit = 1'b1;
                  state_n    = S_IDLE;
               end else begin
                  byte_ok = 1'b1;
                  state_n = S_IDLE;
               end
            end
         end
         S_BREAK: begin
            if (rxs) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Bit timing, bit index, shift register and parity tracking.
   always_ff @(posedge clk or posedge ap_rst) begin
      if (ap_rst) begin
         bcnt    <= '0;
         idx     <= '0;
         shift   <= '0;
         par_lat <= 1'b0;
         par_bad <= 1'b0;
      end else begin
         bcnt <= ((state_n == S_IDLE) || bit_end) ? 10'd0 : bcnt + 10'd1;
         if (idx_clr)      idx <= 3'd0;
         else if (idx_inc) idx <= idx + 3'd1;
         if (shift_en) shift <= {rxs, shift[7:1]};
         if (par_latch) begin
            par_lat <= parity_en;
            par_bad <= 1'b0;
         end else if (par_check && (rxs != ^shift)) begin
            par_bad <= 1'b1;
         end
      end
   end

   // Word assembly: lanes 0..2 are staged, lane 3 completes the word.
   // Any error restarts assembly so partial words are discarded.
   always_ff @(posedge clk or posedge ap_rst) begin
      if (ap_rst) begin
         byte_idx <= '0;
         asm_lo   <= '0;
      end else if (frame_hit || parity_hit) begin
         byte_idx <= 2'd0;
      end else if (byte_ok) begin
         byte_idx <= byte_idx + 2'd1;
         case (byte_idx)
            2'd0:    asm_lo[7:0]   <= shift;
            2'd1:    asm_lo[15:8]  <= shift;
            2'd2:    asm_lo[23:16] <= shift;
            default: ;
         endcase
      end
   end

   // Output handshake: ap_vaild holds with data stable until a rising edge
   // with ap_ready high; a word completing on that same edge replaces it,
   // while a word completing with ap_vaild high and ap_ready low is dropped
   // and flagged as overrun. Error pulses are registered one-cycle strobes.
   always_ff @(posedge clk or posedge ap_rst) begin
      if (ap_rst) begin
         ap_vaild   <= 1'b0;
         data       <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= frame_hit;
         parity_err <= parity_hit;
         overrun    <= 1'b0;
         if (word_done) begin
            if (!ap_vaild || ap_ready) begin
               data     <= {shift, asm_lo};
               ap_vaild <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (ap_vaild && ap_ready) begin
            ap_vaild <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at CLKS_PER_BIT=16: clean words, parity,
// framing/break, glitch rejection, overrun, same-edge reload and reset.
module tb_uart_rx_word;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_STOP  = 3'd4;
   localparam logic [2:0] ST_BREAK = 3'd5;

   logic        clk = 1'b0;
   logic        ap_rst, rx, parity_en, ap_ready;
   logic        ap_vaild, frame_err, parity_err, overrun;
   logic [31:0] data;
   logic [2:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int n_frame = 0;
   int n_par = 0;
   int n_ovr = 0;
   logic [31:0] exp_q[$];

   uart_rx_word #(.CLKS_PER_BIT(16)) dut (
      .clk(clk), .ap_rst(ap_rst), .rx(rx), .parity_en(parity_en),
      .ap_ready(ap_ready), .ap_vaild(ap_vaild), .data(data),
      .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun),
      .dbg_state(dbg_state)
   );

   // clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // error pulse counters
   always @(posedge clk) begin
      if (frame_err === 1'b1)  n_frame++;
      if (parity_err === 1'b1) n_par++;
      if (overrun === 1'b1)    n_ovr++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      tick(16);
   endtask

   task automatic send_head(input logic [7:0] b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic par_on,
                            input logic par_flip, input logic stop_v);
      send_head(b);
      if (par_on) send_bit((^b) ^ par_flip);
      send_bit(stop_v);
   endtask

   task automatic send_bytes(input logic [31:0] w, input logic par_on);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], par_on, 1'b0, 1'b1);
   endtask

   task automatic send_word(input logic [31:0] w, input logic par_on);
      exp_q.push_back(w);
      send_bytes(w, par_on);
   endtask

   task automatic check_word(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=empty_queue expected=word", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_vaild"}, {31'd0, ap_vaild}, 32'd1);
         check({tag, "_data"}, data, e);
      end
   endtask

   task automatic consume(input string tag);
      ap_ready = 1'b1;
      tick(1);
      ap_ready = 1'b0;
      check(tag, {31'd0, ap_vaild}, 32'd0);
   endtask

   // directed stimulus
   initial begin
      logic [2:0] max_state;
      logic       found;

      ap_rst = 1'b1; rx = 1'b1; parity_en = 1'b0; ap_ready = 1'b0;
      tick(3);
      check("rst_vaild", {31'd0, ap_vaild}, 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_frame", {31'd0, frame_err}, 32'd0);
      check("rst_parity", {31'd0, parity_err}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      ap_rst = 1'b0;
      tick(5);

      // clean word, parity off
      send_byte(8'h11, 1'b0, 1'b0, 1'b1);
      send_byte(8'h22, 1'b0, 1'b0, 1'b1);
      send_byte(8'h33, 1'b0, 1'b0, 1'b1);
      check("clean_partial", {31'd0, ap_vaild}, 32'd0);
      exp_q.push_back(32'h44332211);
      send_byte(8'h44, 1'b0, 1'b0, 1'b1);
      tick(4);
      check_word("clean");
      tick(20);
      check("clean_hold_vaild", {31'd0, ap_vaild}, 32'd1);
      check("clean_hold_data", data, 32'h44332211);
      check("clean_no_err", n_frame + n_par + n_ovr, 32'd0);
      consume("clean_consume");

      // parity on: good word, then bad parity drops partial word
      parity_en = 1'b1;
      send_word(32'h030201A5, 1'b1);
      tick(4);
      check_word("par_good");
      check("par_good_noerr", n_par, 32'd0);
      consume("par_good_consume");
      send_byte(8'h77, 1'b1, 1'b0, 1'b1);
      send_byte(8'hA5, 1'b1, 1'b1, 1'b1);
      tick(4);
      check("par_bad_pulse", n_par, 32'd1);
      check("par_bad_noword", {31'd0, ap_vaild}, 32'd0);
      send_word(32'h40302010, 1'b1);
      tick(4);
      check_word("par_after");
      consume("par_after_consume");
      parity_en = 1'b0;

      // framing error, break hold, recovery
      send_byte(8'h55, 1'b0, 1'b0, 1'b1);
      send_byte(8'h66, 1'b0, 1'b0, 1'b1);
      send_byte(8'h99, 1'b0, 1'b0, 1'b0);
      tick(40);
      check("frame_pulse", n_frame, 32'd1);
      check("frame_break", {29'd0, dbg_state}, {29'd0, ST_BREAK});
      check("frame_noword", {31'd0, ap_vaild}, 32'd0);
      rx = 1'b1;
      tick(5);
      check("frame_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      send_word(32'hEFBEADDE, 1'b0);
      tick(4);
      check_word("frame_after");
      consume("frame_after_consume");

      // glitch: 3 low cycles must not get past START
      max_state = ST_IDLE;
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (dbg_state > max_state) max_state = dbg_state;
      end
      check("glitch_max_state", {29'd0, max_state}, {29'd0, ST_START});
      check("glitch_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      check("glitch_noword", {31'd0, ap_vaild}, 32'd0);
      check("glitch_noerr", n_frame + n_par + n_ovr, 32'd2);

      // overrun: second word dropped while first is pending
      send_word(32'h04030201, 1'b0);
      tick(4);
      check_word("ovr_first");
      send_bytes(32'h08070605, 1'b0);
      tick(4);
      check("ovr_pulse", n_ovr, 32'd1);
      check("ovr_keep_vaild", {31'd0, ap_vaild}, 32'd1);
      check("ovr_keep_data", data, 32'h04030201);

      // word completes on the same edge that ap_ready accepts the old one
      send_byte(8'h0A, 1'b0, 1'b0, 1'b1);
      send_byte(8'h0B, 1'b0, 1'b0, 1'b1);
      send_byte(8'h0C, 1'b0, 1'b0, 1'b1);
      send_head(8'h0D);
      rx = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (dbg_state == ST_STOP) found = 1'b1;
      end
      check("same_stop_seen", {31'd0, found}, 32'd1);
      tick(7);
      ap_ready = 1'b1;
      tick(1);
      ap_ready = 1'b0;
      check("same_vaild", {31'd0, ap_vaild}, 32'd1);
      check("same_data", data, 32'h0D0C0B0A);
      check("same_no_ovr", n_ovr, 32'd1);
      tick(20);

      // reset in the middle of byte 1 with a word still pending
      send_byte(8'h12, 1'b0, 1'b0, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      ap_rst = 1'b1;
      tick(2);
      check("midrst_vaild", {31'd0, ap_vaild}, 32'd0);
      check("midrst_data", data, 32'd0);
      check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      rx = 1'b1;
      ap_rst = 1'b0;
      tick(20);
      send_word(32'hCAFEBABE, 1'b0);
      tick(4);
      check_word("midrst_after");
      consume("midrst_consume");
      check("final_frame_cnt", n_frame, 32'd1);
      check("final_par_cnt", n_par, 32'd1);
      check("final_ovr_cnt", n_ovr, 32'd1);
      check("final_queue_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
